div32_seq: RTL and testbench
============================

// Module: div32_seq
// PURPOSE
//  Multi-cycle 32-bit integer divider sequencer for the ALU. One shared addsub32 instance does
//  one restoring-division step per cycle under an FSM; start/busy/done handshake to the ALU.
//  Sits beside the single-cycle ALU datapath and serves DIV/DIVU/REM/REMU ops.
// PARAMETERS
//  WIDTH   32   operand/result width; also the ITER step count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; accepted only in IDLE or DONE
//  is_signed    in   1      1 = two's-complement division, 0 = unsigned; sampled with start
//  dividend     in   WIDTH  sampled on the accepting edge
//  divisor      in   WIDTH  sampled on the accepting edge
//  busy         out  1      1 in PREP/ITER/FIX
//  done         out  1      one-cycle pulse; quotient/remainder valid in that cycle
//  quotient     out  WIDTH  registered result, held until next done
//  remainder    out  WIDTH  registered result, held until next done
//  div_by_zero  out  1      registered flag, updated together with quotient
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Applies from any
//    state, including mid-ITER: the operation is abandoned and no done is issued.
//  - States and transitions:
//    IDLE -start-> PREP
//    PREP -> DONE (divisor==0) else ITER
//    ITER (WIDTH cycles) -> FIX
//    FIX -> DONE
//    DONE -start-> PREP, else IDLE
//  - start in PREP/ITER/FIX is ignored; operands are not re-sampled.
//  - PREP: register |dividend| and |divisor| (magnitudes when is_signed, raw otherwise); record
//    sign_q = sd^sv and sign_r = sd, where sd/sv are the sign bits.
//    Clear partial remainder R (WIDTH+1 bits) and step counter.
//  - ITER step i: shifted = {R[WIDTH-1:0], next dividend MSB}. The adder computes
//    shifted[WIDTH-1:0] - D with sub=1, c_in=1.
//    qbit = c_out | shifted[WIDTH]; if qbit, R <= diff, else R <= shifted.
//    qbit shifts into the quotient LSB. The counter wraps at WIDTH-1 -> FIX.
//  - FIX: if is_signed, negate the quotient when sign_q and the remainder when sign_r. Otherwise
//    pass through. Write the output registers.
//  - Divide by zero (both modes): quotient=all-ones, remainder=original dividend,
//    div_by_zero=1. Skips ITER/FIX; done is asserted 2 cycles after the accepting edge.
//  - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0. This falls out of the
//    magnitude algorithm; no special case.
//  - Latency: accepting edge at cycle 0 -> done high in cycle WIDTH+3 (35).
//    Throughput with start held in DONE: one op per WIDTH+3 cycles.
//  - The adder is owned solely by this block. Its a/b are muxed to 0 outside ITER, so it does
//    not toggle when idle.
// STRUCTURE
//  - Shared header div_defs.vh: state encodings (IDLE, PREP, ITER, FIX, DONE, 3-bit),
//    DIV0_QUOTIENT = all-ones, counter width = clog2(WIDTH).
//  - One sub-module: the existing addsub32 (a=shifted low bits, b=divisor magnitude, sub=1,
//    c_in=1).
//  - Magnitude/negate is a local function (~x+1), not a second adder instance.
//  - FSM and datapath registers stay in this file.
// TESTING
//  1. unsigned 100/7 -> q=14, r=2, div_by_zero=0; done exactly at cycle 35, busy high cycles 1-34.
//  2. signed -100/7 (0xFFFFFF9C/7) -> q=0xFFFFFFF2, r=0xFFFFFFFE; signed 100/-7 -> q=0xFFFFFFF2, r=2.
//  3. unsigned 0x1234/0 -> q=0xFFFFFFFF, r=0x1234, div_by_zero=1, done at cycle 2;
//     signed -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
//  4. signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0;
//     unsigned 0xFFFFFFFF/0x80000000 -> q=1, r=0x7FFFFFFF (exercises the shifted[WIDTH] path).
//  5. start pulsed again at ITER cycle 5 with other operands -> ignored, first result intact;
//     start held through DONE -> next op accepted, next done 35 cycles later.
//  6. rst at ITER cycle 10 -> next cycle busy=0, outputs 0, no done;
//     then unsigned 7/7 -> q=1, r=0 at cycle 35.

Source files
------------

// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg: shared definitions for the sequential integer divider.
//   DIV_WIDTH : default operand/result width (also the number of ITER steps)
//   state_t   : divider FSM state encoding (3-bit)
package div32_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/addsub32.sv
// addsub32: combinational adder/subtractor.
//   a, b   : operands
//   sub    : 1 = invert b (a - b when c_in = 1)
//   c_in   : carry in
//   sum    : result
//   c_out  : carry out (for subtraction: 1 means a >= b, unsigned)
module addsub32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff        = b ^ {WIDTH{sub}};
    assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   start        : request, accepted only in IDLE or DONE
//   is_signed    : 1 = two's-complement, 0 = unsigned (sampled with start)
//   dividend     : sampled on the accepting edge
//   divisor      : sampled on the accepting edge
//   busy         : high in PREP/ITER/FIX
//   done         : one-cycle pulse, results valid in that cycle
//   quotient     : registered result, held until the next done
//   remainder    : registered result, held until the next done
//   div_by_zero  : registered flag, updated with quotient
// One addsub32 instance performs one trial subtraction per ITER cycle.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state, state_nx;

    // operands captured on the accepting edge
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_signed;

    // iteration datapath
    logic [WIDTH-1:0] dq;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dmag;    // divisor magnitude
    logic [WIDTH-1:0] rem_q;   // partial remainder; always < dmag so WIDTH bits hold it
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;

    logic [WIDTH:0]   shifted; // extra top bit carries the overflow of the shift
    logic [WIDTH-1:0] add_a, add_b, diff;
    logic             c_out, qbit;
    logic             accept, div0, last_step, in_iter;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign div0      = (op_b == '0);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign in_iter   = (state == ST_ITER);

    assign shifted = {rem_q, dq[WIDTH-1]};

    // Adder inputs are forced to zero outside ITER so it stays quiet when idle.
    assign add_a = in_iter ? shifted[WIDTH-1:0] : '0;
    assign add_b = in_iter ? dmag : '0;

    addsub32 #(.WIDTH(WIDTH)) u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (1'b1),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (c_out)
    );

    // A set top bit means shifted >= 2^WIDTH > dmag, so subtraction always fits.
    assign qbit = c_out | shifted[WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nx = ST_PREP;
            ST_PREP: begin
                busy     = 1'b1;
                state_nx = div0 ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                busy = 1'b1;
                if (last_step) state_nx = ST_FIX;
            end
            ST_FIX: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = start ? ST_PREP : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            op_signed   <= 1'b0;
            dq          <= '0;
            dmag        <= '0;
            rem_q       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_a      <= dividend;
                op_b      <= divisor;
                op_signed <= is_signed;
            end
            case (state)
                ST_PREP: begin
                    dq     <= mag(op_a, op_signed);
                    dmag   <= mag(op_b, op_signed);
                    // signs only matter in signed mode, so fold the mode in here
                    sign_q <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    sign_r <= op_signed & op_a[WIDTH-1];
                    rem_q  <= '0;
                    cnt    <= '0;
                    if (div0) begin
                        quotient    <= '1;
                        remainder   <= op_a;
                        div_by_zero <= 1'b1;
                    end
                end
                ST_ITER: begin
                    rem_q <= qbit ? diff : shifted[WIDTH-1:0];
                    dq    <= {dq[WIDTH-2:0], qbit};
                    cnt   <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    quotient    <= sign_q ? neg(dq) : dq;
                    remainder   <= sign_r ? neg(rem_q) : rem_q;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    div32_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                    chk("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Cycle in which start is sampled is cycle 0; done expected at 35 (2 for /0).
    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.lat = dbz ? 2 : 35;
        e.acc = cyc - 1;
        sb.push_back(e);
    endtask

    task automatic accept_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic [31:0] r, input logic dbz);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        push_exp(q, r, dbz);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_err;
        int k;

        vecs[0]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
        vecs[2]  = '{1'b0, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1};
        vecs[3]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[8]  = '{1'b0, 32'd5,        32'd10,       32'd0,        32'd5,        1'b0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[10] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[11] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0};
        vecs[13] = '{1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b1};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 100/7 with busy window check: busy in cycles 1..34, low at 35
        accept_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        busy_err = (busy !== 1'b1) ? 1 : 0;
        for (k = 2; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (busy !== (k <= 34)) busy_err++;
        end
        chk("busy_window_errors", busy_err, 32'd0);
        wait_drain();

        foreach (vecs[i]) begin
            accept_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
            wait_drain();
        end

        // start pulsed during ITER cycle 5 must be ignored
        accept_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        repeat (6) @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd55; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start held through DONE: back-to-back acceptance
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
        @(posedge clk);
        #1;
        push_exp(32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd1000000; divisor = 32'd999;
        k = 0;
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (done === 1'b1) break;
        end
        if (k >= 60) begin
            nvec++;
            nerr++;
            $display("FAIL held_start_done_timeout: got no done expected done within 60 cycles");
        end else begin
            @(posedge clk);
            #1;
            push_exp(32'd1001, 32'd1, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // reset during ITER cycle 10 abandons the op
        accept_op(1'b0, 32'd50000, 32'd7, 32'd7142, 32'd6, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        accept_op(1'b0, 32'd7, 32'd7, 32'd1, 32'd0, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
